// File: rtl/cla_nibble_serial_adder.sv
// Nibble-serial wide adder/subtractor built around one 4-bit carry-look-ahead
// slice. Operands are latched on accept, one nibble is summed per clock, and the
// slice carry is registered between nibbles.

// 4-bit carry-look-ahead slice: all carries computed directly from g/p terms.
module cla_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  // Generate/propagate terms and flattened look-ahead carries.
  always_comb begin
    w_g    = a & b;
    w_p    = a ^ b;
    w_c[0] = c_in;
    w_c[1] = w_g[0] | (w_p[0] & c_in);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c_in);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & c_in);
    w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0]) | (&w_p & c_in);
  end

  assign sum   = w_p ^ w_c[3:0];
  assign c_out = w_c[4];

endmodule

module cla_nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int unsigned N  = WIDTH / 4;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state, w_state_next;
  logic [KW-1:0]    r_k, w_k_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic             r_carry;

  logic [KW+1:0]    w_shamt;
  logic [WIDTH-1:0] w_a_sh, w_b_sh, w_sum_next;
  logic [3:0]       w_nib_sum;
  logic             w_nib_cout;
  logic             w_last;

  // Current nibble of the latched operands, selected by the nibble counter.
  always_comb begin
    w_shamt = {r_k, 2'b00};
    w_a_sh  = r_a >> w_shamt;
    w_b_sh  = r_b >> w_shamt;
    w_last  = (r_k == KW'(N - 1));
  end

  cla_4b u_cla (
    .a     (w_a_sh[3:0]),
    .b     (w_b_sh[3:0]),
    .c_in  (r_carry),
    .sum   (w_nib_sum),
    .c_out (w_nib_cout)
  );

  // Splice the slice sum into nibble k of the running result.
  always_comb begin
    w_sum_next = (r_sum & ~(WIDTH'(4'hF) << w_shamt)) | (WIDTH'(w_nib_sum) << w_shamt);
  end

  // State and nibble counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_k     <= '0;
    end else begin
      r_state <= w_state_next;
      r_k     <= w_k_next;
    end
  end

  // Next-state logic; k saturates at N-1 on the final RUN edge.
  always_comb begin
    w_state_next = r_state;
    w_k_next     = r_k;
    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_state_next = StRun;
          w_k_next     = '0;
        end
      end
      StRun: begin
        if (w_last) w_state_next = StDone;
        else        w_k_next     = r_k + 1'b1;
      end
      StDone: begin
        if (out_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Operand latch on accept; per-nibble sum and carry update while running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else if (r_state == StIdle && in_valid) begin
      r_a     <= a;
      r_b     <= op_sub ? ~b : b;
      r_carry <= op_sub ? 1'b1 : c_in;
    end else if (r_state == StRun) begin
      r_sum   <= w_sum_next;
      r_carry <= w_nib_cout;
    end
  end

  // Outputs come straight from registers so they hold under backpressure.
  always_comb begin
    in_ready  = (r_state == StIdle);
    out_valid = (r_state == StDone);
    sum       = r_sum;
    c_out     = r_carry;
    overflow  = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (r_sum[WIDTH-1] != r_a[WIDTH-1]);
  end

endmodule
